mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. It succeeds the 3-bit JK ripple counter with one clock for every bit, selectable width and modulus, count direction, parallel load and wrap or saturate mode. It also provides a terminal-count output for cascading several stages into wider or decade chains.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 1.
- MODULUS, 10: count range is 0 to MODULUS-1; requires 2 ≤ MODULUS ≤ 2**WIDTH.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.

- clk  input  1  single clock; all state updates on the rising edge.
- clr  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous clear, active-high.
- enable  input  1  count enable, active-high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load, active-high.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse.
- at_limit  output  1  registered saturation flag.

## Operation
- MAX is defined as MODULUS-1.
- Per-edge priority, highest first: clr, then sclr, then load, then enable, then hold.
- clr low: q, wrap and at_limit clear to 0 immediately, independent of clk.
- sclr high: q becomes 0, wrap becomes 0, at_limit becomes 0.
- load high:
  - q becomes din if din ≤ MAX, otherwise q becomes MAX (clamped).
  - wrap becomes 0.
  - load overrides enable in the same cycle.
- enable high, up = 1:
  - If q < MAX: q becomes q+1.
  - If q = MAX and SATURATE = 0: q becomes 0 and wrap becomes 1 for one cycle.
  - If q = MAX and SATURATE = 1: q stays MAX and at_limit becomes 1.
- enable high, up = 0:
  - If q > 0: q becomes q-1.
  - If q = 0 and SATURATE = 0: q becomes MAX and wrap becomes 1.
  - If q = 0 and SATURATE = 1: q stays 0 and at_limit becomes 1.
- enable low: q holds and wrap becomes 0.
- at_limit clears on any edge where q moves off the limit (count away, load, sclr).
  - With SATURATE = 0, at_limit is always 0.
- tc = enable AND ((up AND q = MAX) OR (NOT up AND q = 0)). It does not depend on load or sclr.
- Cascading: stage n+1 enable connects to stage n tc; all stages share clk and clr. No clock is derived from a q bit.
- A direction change takes effect on the same edge it is sampled. There is no pipeline.
- Arithmetic uses WIDTH bits. When MODULUS = 2**WIDTH, wrap follows natural overflow. Otherwise explicit compare-to-MAX is used. Out-of-range codes above MAX reach q only through a clamped load, so they never occur.

## Timing
- Latency: one clk edge from sampled control to the new q value. tc is valid in the same cycle as q.
- wrap is asserted in the cycle after the wrapping edge and is high for exactly one cycle per wrap.
- Back-to-back wraps (MODULUS = 2, continuous enable) give wrap high every other cycle, up or down.
- Reset release: the first counting edge is the first rising clk edge with clr high. Asserting clr mid-count zeroes q within the same cycle, without waiting for clk.
- Simultaneous sclr, load and enable: sclr wins, q becomes 0.
- Simultaneous load and enable at q = MAX: load wins, no wrap pulse.

## Test plan
- Reset and count, MODULUS = 10, WIDTH = 4, up = 1, enable held: after clr releases, q steps 0,1,…,9,0. wrap is high only in the cycle where q = 0 after 9. tc is high while q = 9.
- Down count and wrap: load din = 2, then count down. q steps 2,1,0,9,8. tc is high at q = 0 and wrap pulses once when q = 9.
- Saturate, SATURATE = 1, count up from 7: q steps 8,9,9,9 and at_limit becomes 1 at the third edge. Switching to up = 0 gives q = 8 and at_limit = 0.
- Load clamp and priority: load din = 13 gives q = 9. Asserting sclr, load and enable together gives q = 0. Asserting load din = 4 with enable at q = 9 gives q = 4 with no wrap.
- Async reset mid-count: drop clr between edges at q = 6. q, wrap and at_limit read 0 before the next edge, and counting resumes from 0 after release.
- Cascade: two stages with MODULUS = 10 and enable of stage 1 tied to tc of stage 0. Over 100 enabled cycles from 00 the pair reads 00…99. tc of stage 1 is high only at 99, then the pair wraps to 00.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, wrap or saturate mode, and a terminal-count output for cascading.
// Latency: one clk edge from sampled control to q; tc is combinational from enable, up and q. No backpressure: enable gates counting.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic             SAT = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    at_limit_d = at_limit_q;
    if (sclr) begin
      count_d    = '0;
      at_limit_d = 1'b0;
    end else if (load) begin
      // Codes above MAX are clamped so q never leaves the modulus range.
      count_d    = (din > MAX) ? MAX : din;
      at_limit_d = 1'b0;
    end else if (enable) begin
      at_limit_d = 1'b0;
      if (up) begin
        if (!at_max) begin
          count_d = count_q + 1'b1;
        end else if (SAT) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - 1'b1;
        end else if (SAT) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign q        = count_q;
  assign wrap     = wrap_q;
  assign at_limit = at_limit_q;
  assign tc       = enable & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: vector table on a wrapping counter, hand sequences for saturate, async reset and a two-stage decade cascade.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // Stage A: wrapping, modulus 10
  logic       a_sclr = 0, a_en = 0, a_up = 0, a_load = 0;
  logic [3:0] a_din = 0, a_q;
  logic       a_tc, a_wrap, a_at;
  // Stage B: saturating, modulus 10
  logic       b_en = 0, b_up = 0, b_load = 0;
  logic [3:0] b_din = 0, b_q;
  logic       b_tc, b_wrap, b_at;
  // Cascade pair
  logic       c_en = 0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_at, c1_at;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
    .clk(clk), .clr(clr), .sclr(a_sclr), .enable(a_en), .up(a_up), .load(a_load),
    .din(a_din), .q(a_q), .tc(a_tc), .wrap(a_wrap), .at_limit(a_at));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
    .clk(clk), .clr(clr), .sclr(1'b0), .enable(b_en), .up(b_up), .load(b_load),
    .din(b_din), .q(b_q), .tc(b_tc), .wrap(b_wrap), .at_limit(b_at));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c0 (
    .clk(clk), .clr(clr), .sclr(1'b0), .enable(c_en), .up(1'b1), .load(1'b0),
    .din(4'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap), .at_limit(c0_at));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c1 (
    .clk(clk), .clr(clr), .sclr(1'b0), .enable(c0_tc), .up(1'b1), .load(1'b0),
    .din(4'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .at_limit(c1_at));

  typedef struct {
    logic       sclr, load, en, up;
    logic [3:0] din;
    logic       exp_tc;   // tc with these inputs applied, before the edge
    logic [3:0] exp_q;    // q after the edge
    logic       exp_wrap; // wrap after the edge
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void add(input logic s, input logic l, input logic e, input logic u,
                              input logic [3:0] d, input logic t, input logic [3:0] eq,
                              input logic w);
    vec_t v;
    v.sclr = s; v.load = l; v.en = e; v.up = u; v.din = d;
    v.exp_tc = t; v.exp_q = eq; v.exp_wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic b_step(input logic e, input logic u, input logic l, input logic [3:0] d,
                        input int eq, input int eat, input string name);
    @(negedge clk);
    b_en = e; b_up = u; b_load = l; b_din = d;
    @(posedge clk); #1;
    check({name, ".q"}, b_q, eq);
    check({name, ".at_limit"}, b_at, eat);
    check({name, ".wrap"}, b_wrap, 0);
  endtask

  initial begin
    // sclr load en up din | tc q wrap
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, 1, 4'd0, (i == 9), (i == 9) ? 4'd0 : 4'(i + 1), (i == 9));
    add(0, 0, 0, 1, 4'd0,  0, 4'd0, 0);
    add(0, 1, 0, 0, 4'd2,  0, 4'd2, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd1, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd0, 0);
    add(0, 0, 1, 0, 4'd0,  1, 4'd9, 1);
    add(0, 0, 1, 0, 4'd0,  0, 4'd8, 0);
    add(0, 1, 0, 1, 4'd13, 0, 4'd9, 0);
    add(0, 1, 1, 1, 4'd4,  1, 4'd4, 0);
    add(1, 1, 1, 1, 4'd7,  0, 4'd0, 0);
    add(0, 0, 1, 0, 4'd0,  1, 4'd9, 1);
    add(0, 0, 0, 0, 4'd0,  0, 4'd9, 0);
    add(0, 0, 1, 1, 4'd0,  1, 4'd0, 1);
    add(0, 0, 1, 1, 4'd0,  0, 4'd1, 0);

    #1;
    check("rst.a_q", a_q, 0);
    check("rst.a_wrap", a_wrap, 0);
    check("rst.a_at", a_at, 0);
    check("rst.b_q", b_q, 0);
    @(negedge clk);
    clr = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_sclr = vecs[i].sclr; a_load = vecs[i].load; a_en = vecs[i].en;
      a_up = vecs[i].up; a_din = vecs[i].din;
      #1;
      check($sformatf("vec%0d.tc", i), a_tc, vecs[i].exp_tc);
      @(posedge clk); #1;
      check($sformatf("vec%0d.q", i), a_q, vecs[i].exp_q);
      check($sformatf("vec%0d.wrap", i), a_wrap, vecs[i].exp_wrap);
      check($sformatf("vec%0d.at_limit", i), a_at, 0);
    end
    @(negedge clk);
    a_sclr = 0; a_load = 0; a_en = 0;

    // Saturating stage: 7 -> 8, 9, 9 (limit), 9, then down to 8
    b_step(0, 1, 1, 4'd7, 7, 0, "sat.load");
    b_step(1, 1, 0, 4'd0, 8, 0, "sat.up1");
    b_step(1, 1, 0, 4'd0, 9, 0, "sat.up2");
    #3 check("sat.tc_at_max", b_tc, 1);
    b_step(1, 1, 0, 4'd0, 9, 1, "sat.up3");
    b_step(1, 1, 0, 4'd0, 9, 1, "sat.up4");
    b_step(1, 0, 0, 4'd0, 8, 0, "sat.down");
    b_step(1, 1, 0, 4'd0, 9, 0, "sat.up5");
    b_step(1, 1, 0, 4'd0, 9, 1, "sat.up6");
    @(negedge clk);
    b_en = 0;

    // Async reset between edges with A at 6 and B saturated
    a_load = 1; a_din = 4'd5;
    @(negedge clk);
    a_load = 0; a_en = 1; a_up = 1;
    @(posedge clk); #1;
    check("arst.pre_q", a_q, 6);
    #2 clr = 1'b0;
    #1;
    check("arst.a_q", a_q, 0);
    check("arst.a_wrap", a_wrap, 0);
    check("arst.b_q", b_q, 0);
    check("arst.b_at", b_at, 0);
    @(posedge clk); #1;
    check("arst.held_q", a_q, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("arst.resume_q", a_q, 1);
    @(negedge clk);
    a_en = 0;

    // Decade cascade 00..99 then wrap
    c_en = 1;
    for (int k = 0; k < 100; k++) begin
      #1;
      check($sformatf("casc%0d.val", k), c1_q * 10 + c0_q, k);
      check($sformatf("casc%0d.tc1", k), c1_tc, (k == 99));
      @(negedge clk);
    end
    #1;
    check("casc.wrap_val", c1_q * 10 + c0_q, 0);
    check("casc.c1_wrap", c1_wrap, 1);
    check("casc.c0_wrap", c0_wrap, 1);
    check("casc.at", c0_at | c1_at, 0);
    c_en = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
